// File: rtl/dpt_pkg.sv
// Shared types and helpers for the double-pulse test sequencer.
package dpt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SELECT   = 4'd1,
    ST_ARM      = 4'd2,
    ST_WAIT_ACK = 4'd3,
    ST_WAIT_RUN = 4'd4,
    ST_COOL     = 4'd5,
    ST_NEXT     = 4'd6,
    ST_FINISH   = 4'd7,
    ST_ERROR    = 4'd8
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_FAULT  = 2'b01;
  localparam logic [1:0] ERR_ACK_TO = 2'b10;
  localparam logic [1:0] ERR_RUN_TO = 2'b11;

  localparam int MAX_CH = 8;

  // Lowest set bit of mask at index >= lo; bit 3 of the result flags a hit.
  function automatic logic [3:0] find_set_from(input logic [MAX_CH-1:0] mask,
                                               input logic [3:0] lo);
    logic [3:0] r;
    r = 4'd0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic bit cyc_ok(input longint c, input int w);
    return (c >= 1) && (c < (longint'(1) << w));
  endfunction

endpackage

// File: rtl/dpt_timer.sv
// Loadable down-counter shared by all timed sequencer states.
module dpt_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/dpt_sequencer.sv
// Steps enabled DUT channels through settle / trigger / cooldown cycles and
// drives the double-pulse engine; any fault, abort or timeout forces the safe state.
module dpt_sequencer
  import dpt_pkg::*;
#(
  parameter int          N_CH       = 4,
  parameter int          CNT_W      = 24,
  parameter int unsigned SETTLE_CYC = 2000,
  parameter int unsigned COOL_CYC   = 40000,
  parameter int unsigned TRIG_CYC   = 2,
  parameter int unsigned ACK_TO     = 16,
  parameter int unsigned RUN_TO     = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            fault,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [7:0]      shots,
  input  logic            dp_busy,
  output logic [N_CH-1:0] ch_sel,
  output logic            dp_enable,
  output logic            dp_trig,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [2:0]      cur_ch,
  output logic [3:0]      dbg_state
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam bit PARAMS_OK = (N_CH >= 1) && (N_CH <= MAX_CH) &&
                             (CNT_W >= 2) && (CNT_W <= 32) &&
                             cyc_ok(longint'(SETTLE_CYC), CNT_W) &&
                             cyc_ok(longint'(COOL_CYC), CNT_W) &&
                             cyc_ok(longint'(TRIG_CYC), CNT_W) &&
                             cyc_ok(longint'(ACK_TO), CNT_W) &&
                             cyc_ok(longint'(RUN_TO), CNT_W);

  if (!PARAMS_OK) begin : g_param_check
    $error("dpt_sequencer: N_CH must be 1..8 and every cycle count 1..2^CNT_W-1");
  end

  state_t           state, state_nxt;
  logic [N_CH-1:0]  mask_q, mask_nxt;
  logic [7:0]       shots_q, shots_nxt;
  logic [7:0]       shot_cnt, shot_cnt_nxt;
  logic [IDX_W-1:0] ch_idx, ch_idx_nxt;
  logic             err_int, err_nxt;
  logic [1:0]       code_int, code_nxt;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expired;

  logic [3:0]       hit_start, hit_next;
  logic             more_shots;

  assign hit_start  = find_set_from(8'(ch_mask), 4'd0);
  assign hit_next   = find_set_from(8'(mask_q), 4'(ch_idx) + 4'd1);
  assign more_shots = ({1'b0, shot_cnt} + 9'd1) < {1'b0, shots_q};
  assign dbg_state  = state;

  dpt_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mask_q   <= '0;
      shots_q  <= '0;
      shot_cnt <= '0;
      ch_idx   <= '0;
      err_int  <= 1'b0;
      code_int <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      mask_q   <= mask_nxt;
      shots_q  <= shots_nxt;
      shot_cnt <= shot_cnt_nxt;
      ch_idx   <= ch_idx_nxt;
      err_int  <= err_nxt;
      code_int <= code_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mask_nxt     = mask_q;
    shots_nxt    = shots_q;
    shot_cnt_nxt = shot_cnt;
    ch_idx_nxt   = ch_idx;
    err_nxt      = err_int;
    code_nxt     = code_int;
    case (state)
      ST_IDLE: begin
        if (start) begin
          mask_nxt  = ch_mask;
          shots_nxt = (shots == 8'd0) ? 8'd1 : shots;
          err_nxt   = 1'b0;
          code_nxt  = ERR_NONE;
          shot_cnt_nxt = '0;
          if (hit_start[3]) begin
            state_nxt  = ST_SELECT;
            ch_idx_nxt = IDX_W'(hit_start[2:0]);
          end else begin
            state_nxt  = ST_FINISH;
            ch_idx_nxt = '0;
          end
        end
      end
      ST_SELECT:   if (tmr_expired) state_nxt = ST_ARM;
      ST_ARM:      if (tmr_expired) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (dp_busy) begin
          state_nxt = ST_WAIT_RUN;
        end else if (tmr_expired) begin
          state_nxt = ST_ERROR;
          err_nxt   = 1'b1;
          code_nxt  = ERR_ACK_TO;
        end
      end
      ST_WAIT_RUN: begin
        if (!dp_busy) begin
          state_nxt = ST_COOL;
        end else if (tmr_expired) begin
          state_nxt = ST_ERROR;
          err_nxt   = 1'b1;
          code_nxt  = ERR_RUN_TO;
        end
      end
      ST_COOL:     if (tmr_expired) state_nxt = ST_NEXT;
      ST_NEXT: begin
        // Further shots on the same channel re-arm with the relay still closed.
        if (more_shots) begin
          shot_cnt_nxt = shot_cnt + 8'd1;
          state_nxt    = ST_ARM;
        end else if (hit_next[3]) begin
          shot_cnt_nxt = '0;
          ch_idx_nxt   = IDX_W'(hit_next[2:0]);
          state_nxt    = ST_SELECT;
        end else begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH:   state_nxt = ST_IDLE;
      ST_ERROR:    if (!start) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase

    // Interlock outranks abort, and both outrank any timeout decided above.
    if (state != ST_IDLE && state != ST_ERROR) begin
      if (fault) begin
        state_nxt = ST_ERROR;
        err_nxt   = 1'b1;
        code_nxt  = ERR_FAULT;
      end else if (abort) begin
        state_nxt = ST_IDLE;
        err_nxt   = err_int;
        code_nxt  = code_int;
      end
    end
  end

  always_comb begin
    tmr_load = (state_nxt != state);
    tmr_val  = '0;
    case (state_nxt)
      ST_SELECT:   tmr_val = CNT_W'(SETTLE_CYC - 1);
      ST_ARM:      tmr_val = CNT_W'(TRIG_CYC - 1);
      ST_WAIT_ACK: tmr_val = CNT_W'(ACK_TO - 1);
      ST_WAIT_RUN: tmr_val = CNT_W'(RUN_TO - 1);
      ST_COOL:     tmr_val = CNT_W'(COOL_CYC - 1);
      default:     ;
    endcase
  end

  logic            sel_on, busy_d, trig_d, done_d;
  logic [N_CH-1:0] ch_sel_d;

  always_comb begin
    sel_on = 1'b0;
    case (state)
      ST_SELECT, ST_ARM, ST_WAIT_ACK, ST_WAIT_RUN, ST_COOL: sel_on = 1'b1;
      ST_NEXT: sel_on = more_shots;
      default: sel_on = 1'b0;
    endcase
    ch_sel_d = sel_on ? (N_CH'(1) << ch_idx) : '0;
    busy_d   = (state != ST_IDLE) && (state != ST_ERROR);
    trig_d   = (state == ST_ARM);
    done_d   = (state == ST_FINISH) && !fault && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel    <= '0;
      dp_enable <= 1'b0;
      dp_trig   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      cur_ch    <= '0;
    end else begin
      ch_sel    <= ch_sel_d;
      dp_enable <= sel_on;
      dp_trig   <= trig_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_int;
      err_code  <= code_int;
      cur_ch    <= busy_d ? 3'(ch_idx) : 3'd0;
    end
  end

endmodule

// File: doc/dpt_sequencer.md
# dpt_sequencer

Test sequencer that drives the double-pulse engine across up to `N_CH` device-under-test channels. On `start` it steps through the enabled channels in ascending order, closes each channel's relay, waits for contacts to settle, fires a programmable number of double-pulse shots with cooldown between them, then releases the relay. Any fault, abort or engine timeout returns all outputs to the safe state. It sits between the host/test-control register block and the pulse engine, which it controls through `dp_enable` / `dp_trig` / `dp_busy`.

## Interface
- `N_CH`, 4: number of DUT channels (1..8)
- `CNT_W`, 24: width of the shared cycle timer
- `SETTLE_CYC`, 2000: relay settle time in cycles (50 µs at 40 MHz)
- `COOL_CYC`, 40000: cooldown between shots in cycles (1 ms)
- `TRIG_CYC`, 2: `dp_trig` high time in cycles
- `ACK_TO`, 16: max cycles from trigger end to `dp_busy` rising
- `RUN_TO`, 4096: max cycles with `dp_busy` high
---
- `clk` in 1: single system clock
- `rst_n` in 1: reset, asynchronous assert, active-low
- `start` in 1: level; a run begins on any IDLE cycle where it is high
- `abort` in 1: stop the run; return to IDLE with no error
- `fault` in 1: external interlock; active high
- `ch_mask` in N_CH: enabled channels, latched at start
- `shots` in 8: shots per channel, latched at start; 0 is treated as 1
- `dp_busy` in 1: engine activity (high during the pulse train)
- `ch_sel` out N_CH: one-hot relay drive
- `dp_enable` out 1: engine enable
- `dp_trig` out 1: engine trigger
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at normal completion
- `err` out 1: sticky error flag
- `err_code` out 2: 00 none, 01 fault, 10 ack timeout, 11 run timeout
- `cur_ch` out 3: index of the active channel

## Operation
- States:
  - IDLE
  - SELECT: relay settling
  - ARM: trigger high
  - WAIT_ACK
  - WAIT_RUN
  - COOL
  - NEXT
  - FINISH
  - ERROR
- Values after reset: state IDLE; every output 0; `err_code` 00.
- IDLE with `start` high:
  - Latch `ch_mask` and `shots`.
  - Clear `err` and `err_code`.
  - If the latched mask is 0, go to FINISH. Otherwise go to SELECT on the lowest set bit.
- SELECT:
  - `ch_sel` is one-hot on `cur_ch`. `dp_enable` goes high.
  - Count SETTLE_CYC cycles, then go to ARM.
- ARM: `dp_trig` is high for TRIG_CYC cycles, then go to WAIT_ACK.
- WAIT_ACK:
  - When `dp_busy` is high, go to WAIT_RUN.
  - After ACK_TO cycles with `dp_busy` low, go to ERROR with code 10.
- WAIT_RUN:
  - When `dp_busy` goes low, go to COOL.
  - After RUN_TO cycles with `dp_busy` high, go to ERROR with code 11.
- COOL: count COOL_CYC cycles, then go to NEXT.
- NEXT:
  - Increment the shot counter.
  - If the count is below the effective shots, go to ARM. The relay stays closed; no re-settle.
  - Otherwise deassert `ch_sel` and search for the next set mask bit above `cur_ch`. If one is found, go to SELECT. If none, go to FINISH.
- FINISH: `done` = 1 for one cycle, then IDLE.
- ERROR:
  - All of `ch_sel`, `dp_enable`, `dp_trig` are 0. `err` = 1.
  - Return to IDLE once `start` is low. `err`/`err_code` hold until the next accepted start.
- `fault` high in any state other than IDLE/ERROR: go to ERROR, code 01. Fault takes priority over abort and over timeouts.
- `abort` high in any state other than IDLE/ERROR: go to IDLE. Outputs are safe, no `done`, `err` unchanged.
- `start` while busy is ignored.
- `busy` = 1 in every state except IDLE and ERROR.

## Timing
- All outputs are registered and decoded from the state.
- `start` sampled at edge n gives `busy`/`ch_sel`/`dp_enable` high from edge n+1.
- First `dp_trig` rises SETTLE_CYC cycles after `ch_sel` rises.
- A `fault` or `abort` sampled at edge n drives `ch_sel`, `dp_enable`, `dp_trig` low after edge n+1 (one-cycle response).
- Between channels, `ch_sel` is all-zero for at least one cycle (NEXT), so two relays are never closed together (break-before-make).
- Shot counter is 8 bits; the channel index is `$clog2(N_CH)` bits, zero-extended into `cur_ch`.
- Timer is down-counting and CNT_W wide. Every *_CYC parameter must be below 2^CNT_W; this is checked at elaboration.

## Structure
- Package `dpt_pkg`:
  - state encoding constants
  - `err_code` constants: ERR_NONE, ERR_FAULT, ERR_ACK_TO, ERR_RUN_TO
- Sub-module `dpt_timer`:
  - loadable CNT_W down-counter with `load`, `value` and `expired` outputs
  - one instance, reloaded on every state entry

## Test plan
Bench parameters: SETTLE=4, COOL=8, TRIG=2, ACK_TO=6, RUN_TO=20; engine model raises `dp_busy` 2 cycles after the trigger and holds it 10 cycles.
- `ch_mask`=4'b0101, `shots`=2, `start` pulse: channel 0 fires 2 triggers, then channel 2 fires 2; `ch_sel` goes 0001 → 0000 → 0100; one `done`; `err`=0.
- `ch_mask`=0, `start`: `done` on the 2nd cycle after start; `ch_sel` never leaves 0.
- Engine never raises `dp_busy`: ERROR with `err_code`=10, 6 cycles after trigger end; outputs 0.
- `fault` during the 2nd WAIT_RUN: outputs 0 within 1 cycle; `err_code`=01. A new `start` clears `err`.
- `abort` during COOL on channel 2: IDLE, no `done`, `err`=0. Also: `fault` and `abort` in the same cycle gives `err_code`=01.
- `rst_n` low mid-SELECT: all outputs 0 immediately; after release, state is IDLE.
